// File: rtl/pic_pkg.sv
// Shared types, constants and helpers for the interrupt acknowledge sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    PULSE1,
    PULSE2,
    PULSE3
  } ack_state_t;

  localparam logic [7:0] CALL_OPCODE    = 8'hCD;
  localparam logic [7:0] SPURIOUS_LEVEL = 8'h80;

  function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (onehot[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// Registers the INTA strobe and flags its falling and rising edges.
module inta_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic inta_q;

  always_ff @(posedge clk) begin
    if (!rst_n) inta_q <= 1'b1;
    else        inta_q <= inta_n;
  end

  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259-style INTA sequencer: requests the CPU, acknowledges the winning level
// and drives the 8086 vector or the 8080 CALL sequence onto the data bus.
module interrupt_ack_sequencer
  import pic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  highest_priority_interrupt,
  input  logic        inta_n,
  input  logic        mode_8086,
  input  logic        auto_eoi,
  input  logic [4:0]  vector_base,
  input  logic [10:0] call_address,
  input  logic        interval_4,
  output logic        int_out,
  output logic        acknowledge,
  output logic [7:0]  ack_level,
  output logic [7:0]  end_of_interrupt,
  output logic [7:0]  data_out,
  output logic        data_out_en
);

  logic       fall, rise;
  ack_state_t state, state_d;
  logic [7:0] cap_level, cap_level_d;
  logic       spurious, spurious_d;
  logic       mode_q, mode_d;
  logic       int_out_d, acknowledge_d, data_out_en_d;
  logic [7:0] ack_level_d, eoi_d, data_out_d;
  logic [2:0] idx;

  inta_edge_detect u_inta_edge_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .inta_n (inta_n),
    .fall   (fall),
    .rise   (rise)
  );

  assign idx = onehot_to_index(cap_level);

  always_comb begin
    state_d       = state;
    cap_level_d   = cap_level;
    spurious_d    = spurious;
    mode_d        = mode_q;
    int_out_d     = int_out;
    acknowledge_d = 1'b0;
    ack_level_d   = '0;
    eoi_d         = '0;
    data_out_d    = data_out;
    data_out_en_d = data_out_en;
    case (state)
      IDLE: begin
        int_out_d = 1'b0;
        if (highest_priority_interrupt != '0) begin
          state_d   = PEND;
          int_out_d = 1'b1;
        end
      end
      PEND: begin
        if (fall) begin
          state_d   = PULSE1;
          int_out_d = 1'b0;
          // mode is frozen here so a mid-cycle change cannot alter the pulse count
          mode_d    = mode_8086;
          if (highest_priority_interrupt == '0) begin
            cap_level_d = SPURIOUS_LEVEL;
            spurious_d  = 1'b1;
          end else begin
            cap_level_d   = highest_priority_interrupt;
            spurious_d    = 1'b0;
            acknowledge_d = 1'b1;
            ack_level_d   = highest_priority_interrupt;
          end
          if (!mode_8086) begin
            data_out_d    = CALL_OPCODE;
            data_out_en_d = 1'b1;
          end
        end
      end
      PULSE1: begin
        if (rise) begin
          state_d       = PULSE2;
          data_out_en_d = 1'b0;
        end
      end
      PULSE2: begin
        if (fall) begin
          data_out_en_d = 1'b1;
          if (mode_q)          data_out_d = {vector_base, idx};
          else if (interval_4) data_out_d = {call_address[2:0], idx, 2'b00};
          else                 data_out_d = {call_address[2:1], idx, 3'b000};
        end else if (rise) begin
          data_out_en_d = 1'b0;
          if (mode_q) begin
            state_d = IDLE;
            if (auto_eoi && !spurious) eoi_d = cap_level;
          end else begin
            state_d = PULSE3;
          end
        end
      end
      PULSE3: begin
        if (fall) begin
          data_out_en_d = 1'b1;
          data_out_d    = call_address[10:3];
        end else if (rise) begin
          data_out_en_d = 1'b0;
          state_d       = IDLE;
          if (auto_eoi && !spurious) eoi_d = cap_level;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      cap_level        <= '0;
      spurious         <= 1'b0;
      mode_q           <= 1'b0;
      int_out          <= 1'b0;
      acknowledge      <= 1'b0;
      ack_level        <= '0;
      end_of_interrupt <= '0;
      data_out         <= '0;
      data_out_en      <= 1'b0;
    end else begin
      state            <= state_d;
      cap_level        <= cap_level_d;
      spurious         <= spurious_d;
      mode_q           <= mode_d;
      int_out          <= int_out_d;
      acknowledge      <= acknowledge_d;
      ack_level        <= ack_level_d;
      end_of_interrupt <= eoi_d;
      data_out         <= data_out_d;
      data_out_en      <= data_out_en_d;
    end
  end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed self-checking bench for interrupt_ack_sequencer.
module tb_interrupt_ack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  highest_priority_interrupt;
  logic        inta_n;
  logic        mode_8086;
  logic        auto_eoi;
  logic [4:0]  vector_base;
  logic [10:0] call_address;
  logic        interval_4;
  logic        int_out;
  logic        acknowledge;
  logic [7:0]  ack_level;
  logic [7:0]  end_of_interrupt;
  logic [7:0]  data_out;
  logic        data_out_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  interrupt_ack_sequencer dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .highest_priority_interrupt (highest_priority_interrupt),
    .inta_n                     (inta_n),
    .mode_8086                  (mode_8086),
    .auto_eoi                   (auto_eoi),
    .vector_base                (vector_base),
    .call_address               (call_address),
    .interval_4                 (interval_4),
    .int_out                    (int_out),
    .acknowledge                (acknowledge),
    .ack_level                  (ack_level),
    .end_of_interrupt           (end_of_interrupt),
    .data_out                   (data_out),
    .data_out_en                (data_out_en)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fall();
    inta_n = 1'b0;
    tick();
  endtask

  task automatic do_rise();
    inta_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; inta_n = 1'b1; highest_priority_interrupt = '0;
    mode_8086 = 1'b1; auto_eoi = 1'b0; vector_base = 5'b01000;
    call_address = 11'h4A5; interval_4 = 1'b1;
    tick(); tick();
    check_eq("rst_int_out", int_out, 0);
    check_eq("rst_ack", acknowledge, 0);
    check_eq("rst_ack_level", ack_level, 0);
    check_eq("rst_eoi", end_of_interrupt, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_en", data_out_en, 0);
    rst_n = 1'b1;
    tick();

    // Fall in IDLE is ignored
    do_fall();
    check_eq("idle_fall_ack", acknowledge, 0);
    check_eq("idle_fall_en", data_out_en, 0);
    check_eq("idle_fall_int", int_out, 0);
    do_rise(); tick();

    // 8086 cycle, level 5
    highest_priority_interrupt = 8'h20;
    tick();
    check_eq("i86_int_out", int_out, 1);
    tick();
    do_fall();
    check_eq("i86_ack", acknowledge, 1);
    check_eq("i86_ack_level", ack_level, 8'h20);
    check_eq("i86_int_low", int_out, 0);
    check_eq("i86_p1_en", data_out_en, 0);
    tick();
    check_eq("i86_ack_once", acknowledge, 0);
    do_rise(); tick();
    do_fall();
    check_eq("i86_vec", data_out, 8'h45);
    check_eq("i86_vec_en", data_out_en, 1);
    highest_priority_interrupt = 8'h01;
    tick();
    check_eq("i86_vec_hold", data_out, 8'h45);
    highest_priority_interrupt = '0;
    tick();
    do_rise();
    check_eq("i86_no_eoi", end_of_interrupt, 0);
    tick();
    check_eq("i86_released", data_out_en, 0);
    check_eq("i86_idle_int", int_out, 0);

    // 8080 cycle, level 3, interval 4, mode toggled mid-cycle
    mode_8086 = 1'b0; highest_priority_interrupt = 8'h08;
    tick();
    do_fall();
    check_eq("i80_ack_level", ack_level, 8'h08);
    check_eq("i80_call", data_out, 8'hCD);
    check_eq("i80_call_en", data_out_en, 1);
    mode_8086 = 1'b1;
    tick(); do_rise(); tick();
    do_fall();
    check_eq("i80_low", data_out, 8'hAC);
    tick(); do_rise(); tick();
    check_eq("i80_gap_en", data_out_en, 0);
    do_fall();
    check_eq("i80_high", data_out, 8'h94);
    check_eq("i80_high_en", data_out_en, 1);
    highest_priority_interrupt = '0;
    tick(); do_rise(); tick();
    check_eq("i80_done_en", data_out_en, 0);
    check_eq("i80_done_int", int_out, 0);

    // 8080 interval 8, level 7
    mode_8086 = 1'b0; interval_4 = 1'b0; highest_priority_interrupt = 8'h80;
    tick();
    do_fall();
    check_eq("i80b_call", data_out, 8'hCD);
    tick(); do_rise(); tick();
    do_fall();
    check_eq("i80b_low", data_out, 8'hB8);
    tick(); do_rise(); tick();
    do_fall();
    check_eq("i80b_high", data_out, 8'h94);
    highest_priority_interrupt = '0;
    tick(); do_rise(); tick();

    // Auto EOI, 8086, level 0
    mode_8086 = 1'b1; auto_eoi = 1'b1; highest_priority_interrupt = 8'h01;
    tick();
    do_fall();
    check_eq("aeoi_ack_level", ack_level, 8'h01);
    tick(); do_rise(); tick();
    do_fall();
    check_eq("aeoi_vec", data_out, 8'h40);
    highest_priority_interrupt = '0;
    tick();
    do_rise();
    check_eq("aeoi_eoi", end_of_interrupt, 8'h01);
    tick();
    check_eq("aeoi_eoi_once", end_of_interrupt, 0);

    // Spurious: request withdrawn before first fall
    highest_priority_interrupt = 8'h04;
    tick();
    check_eq("spur_int_out", int_out, 1);
    highest_priority_interrupt = '0;
    tick();
    do_fall();
    check_eq("spur_no_ack", acknowledge, 0);
    check_eq("spur_int_low", int_out, 0);
    tick(); do_rise(); tick();
    do_fall();
    check_eq("spur_vec", data_out, 8'h47);
    tick();
    do_rise();
    check_eq("spur_no_eoi", end_of_interrupt, 0);
    tick();
    check_eq("spur_no_eoi2", end_of_interrupt, 0);

    // Reset during PULSE2
    highest_priority_interrupt = 8'h02;
    tick();
    do_fall(); tick(); do_rise(); tick();
    do_fall();
    check_eq("rmid_en_before", data_out_en, 1);
    rst_n = 1'b0;
    tick();
    check_eq("rmid_en", data_out_en, 0);
    check_eq("rmid_int", int_out, 0);
    rst_n = 1'b1; inta_n = 1'b1; highest_priority_interrupt = '0;
    tick(); tick();
    check_eq("rmid_no_eoi", end_of_interrupt, 0);
    check_eq("rmid_idle_int", int_out, 0);

    // Back-to-back: second request present at the final rise
    auto_eoi = 1'b0; highest_priority_interrupt = 8'h10;
    tick();
    check_eq("b2b_int_out", int_out, 1);
    do_fall();
    check_eq("b2b_ack_level", ack_level, 8'h10);
    tick(); do_rise(); tick();
    do_fall();
    check_eq("b2b_vec1", data_out, 8'h44);
    highest_priority_interrupt = 8'h40;
    tick();
    check_eq("b2b_vec1_hold", data_out, 8'h44);
    do_rise();
    check_eq("b2b_int_rise1", int_out, 0);
    tick();
    check_eq("b2b_int_rise2", int_out, 1);
    do_fall();
    check_eq("b2b_ack2", acknowledge, 1);
    check_eq("b2b_ack_level2", ack_level, 8'h40);
    tick(); do_rise(); tick();
    do_fall();
    check_eq("b2b_vec2", data_out, 8'h46);
    highest_priority_interrupt = '0;
    tick(); do_rise(); tick();
    check_eq("b2b_done_en", data_out_en, 0);
    check_eq("b2b_done_int", int_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_ack_sequencer.md
INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst_n  in  1  reset, synchronous, active low.
REQ-004 highest_priority_interrupt  in  8  one-hot winning request from the priority resolver; 0 means none.
REQ-005 inta_n  in  1  CPU interrupt-acknowledge strobe, active low, synchronous to clk.
REQ-006 mode_8086  in  1  1 = two-pulse 8086 cycle, 0 = three-pulse 8080 cycle.
REQ-007 auto_eoi  in  1  1 = automatic end of interrupt at the end of the last pulse.
REQ-008 vector_base  in  5  ICW2[7:3], T7..T3 for 8086 vectors.
REQ-009 call_address  in  11  {ICW2[7:0], ICW1[7:5]}, A15..A5 for the 8080 CALL.
REQ-010 interval_4  in  1  1 = 8080 call-address interval of 4, 0 = interval of 8.
REQ-011 int_out  out  1  interrupt request to the CPU.
REQ-012 acknowledge  out  1  one-cycle pulse to the ISR to set the in-service bit.
REQ-013 ack_level  out  8  one-hot level being acknowledged; valid while acknowledge=1.
REQ-014 end_of_interrupt  out  8  one-hot level cleared by auto EOI; nonzero for exactly one cycle.
REQ-015 data_out  out  8  byte driven to the CPU data bus.
REQ-016 data_out_en  out  1  bus-drive enable for data_out.

Function
REQ-017 inta_n SHALL be registered into inta_q; fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
REQ-018 The FSM SHALL have the states IDLE, PEND, PULSE1, PULSE2 and PULSE3.
REQ-019 IDLE: when highest_priority_interrupt != 0, the FSM SHALL go to PEND and int_out SHALL be 1 from the next cycle.
REQ-020 PEND: on fall, the block SHALL capture highest_priority_interrupt into cap_level and go to PULSE1.
  - int_out SHALL be 0 from the cycle after fall.
REQ-021 Spurious case: if the captured value is 0, cap_level SHALL be 8'b1000_0000 (IR7) and acknowledge SHALL NOT pulse.
REQ-022 For a non-spurious capture, acknowledge SHALL be 1 for exactly the cycle after fall, with ack_level = cap_level.
REQ-023 PULSE1 data_out:
  - mode_8086=1: data_out_en SHALL stay 0.
  - mode_8086=0: data_out SHALL be 8'hCD with data_out_en=1.
REQ-024 PULSE1 transition: on rise, the FSM SHALL go to PULSE2.
REQ-025 PULSE2 drive window: data_out_en SHALL be 1 from the cycle after fall until the cycle after rise; data_out is held stable in that window.
REQ-026 PULSE2, 8086 mode: data_out SHALL be {vector_base, idx[2:0]}, where idx is the binary index of cap_level.
REQ-027 PULSE2, 8080 mode: data_out SHALL be the low address byte.
  - interval_4=1: {A7..A5, idx, 2'b00}.
  - interval_4=0: {A7, A6, idx, 3'b000}.
REQ-028 PULSE2 transition: on rise, the FSM SHALL go to IDLE (8086) or to PULSE3 (8080).
REQ-029 PULSE3 SHALL drive call_address[10:3] (A15..A8) in the same drive window, then go to IDLE on rise.
REQ-030 On the final rise, if auto_eoi=1 and the capture was not spurious, end_of_interrupt SHALL equal cap_level for one cycle.
REQ-031 While rst_n=1, fall in IDLE SHALL be ignored: no acknowledge and no drive.
REQ-032 While rst_n=1, a change of highest_priority_interrupt after capture SHALL have no effect on the cycle in progress.
REQ-033 A new request present at the final rise SHALL return the FSM through IDLE to PEND, with int_out=1 two cycles after rise.
REQ-034 Changes to mode_8086 mid-cycle SHALL take effect only from the next PEND capture.

Reset
REQ-035 While rst_n=0 at a clk edge, the following SHALL hold:
  - FSM in IDLE; inta_q=1; cap_level=0.
  - int_out=0, acknowledge=0, ack_level=0, end_of_interrupt=0, data_out=0, data_out_en=0.
REQ-036 Reset asserted mid-sequence SHALL abort the cycle with no EOI pulse and the bus released on the next edge.

Structure
REQ-037 The shared package pic_pkg SHALL hold:
  - the FSM state enum;
  - the constants CALL_OPCODE=8'hCD and SPURIOUS_LEVEL=8'h80;
  - a one-hot-to-index function.
REQ-038 The inta_n register and edge detect SHALL be a sub-module named inta_edge_detect; all other logic is flat.

Verification
REQ-039 8086 cycle: vector_base=5'b01000, highest_priority_interrupt=8'b0010_0000, two INTA pulses -> acknowledge pulse with ack_level=8'h20; second pulse drives data_out=8'h45; int_out=0 after the first fall.
REQ-040 8080 cycle: call_address=11'h4A5 (A15..A8=8'h94, A7..A5=3'b101), interval_4=1, level 3 -> data_out sequence CD, AC, 94 over three pulses.
REQ-041 Auto EOI: auto_eoi=1, level 0, 8086 mode -> end_of_interrupt=8'h01 for exactly one cycle after the second rise.
REQ-042 Spurious: request withdrawn before the first fall -> no acknowledge, vector uses index 7 (8086 with base 8'h40 gives 8'h47), no EOI.
REQ-043 Reset mid-cycle: rst_n=0 during PULSE2 -> data_out_en=0 and int_out=0 next edge; FSM returns to IDLE.
REQ-044 Back-to-back: a second request is held through the final rise -> int_out reasserts two cycles after rise, and the second cycle completes correctly.
